// File: rtl/vector_sequencer.sv
// Vector sequencer: replays a loaded table of {chk, vrst, vin, exp} entries into a DUT,
// one vector per clock. The DUT response is compared against the expected value a fixed
// number of cycles after launch. A saturating error count and the index of the first
// mismatching vector are reported.
module vector_sequencer #(
  parameter int unsigned IN_W    = 8,
  parameter int unsigned OUT_W   = 19,
  parameter int unsigned DEPTH   = 66,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned CHK_LAT = 1,
  parameter int unsigned ERR_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_en,
  input  logic [ADDR_W-1:0]       ld_addr,
  input  logic [2+IN_W+OUT_W-1:0] ld_data,
  input  logic [ADDR_W:0]         len,
  input  logic                    loop_en,
  input  logic                    start,
  input  logic                    abort,
  input  logic [OUT_W-1:0]        dut_out,
  output logic                    dut_rst,
  output logic [IN_W-1:0]         dut_in,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       vec_idx,
  output logic [ERR_W-1:0]        err_cnt,
  output logic [ADDR_W-1:0]       first_err,
  output logic                    err_seen
);

  localparam int unsigned EntW = 2 + IN_W + OUT_W;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e            state_q;
  logic [EntW-1:0]   table_q [DEPTH];
  logic [ADDR_W-1:0] last_idx_q;
  logic              loop_q;
  logic [2:0]        drain_q;

  // Compare pipeline: one slot per cycle of check latency.
  logic              pipe_vld_q [CHK_LAT];
  logic              pipe_chk_q [CHK_LAT];
  logic [OUT_W-1:0]  pipe_exp_q [CHK_LAT];
  logic [ADDR_W-1:0] pipe_idx_q [CHK_LAT];

  logic              launch;
  logic [ADDR_W-1:0] launch_idx;
  logic [EntW-1:0]   launch_ent;
  logic              ent_chk;
  logic              ent_rst;
  logic [IN_W-1:0]   ent_in;
  logic [OUT_W-1:0]  ent_exp;
  logic              flush;
  logic              clr;
  logic              mismatch;

  // Decide whether a vector is launched this cycle and which table entry it is.
  always_comb begin
    launch     = 1'b0;
    launch_idx = '0;
    case (state_q)
      StIdle: begin
        if (start && (len != '0)) begin
          launch     = 1'b1;
          launch_idx = '0;
        end
      end
      StRun: begin
        if (!abort) begin
          if (vec_idx == last_idx_q) begin
            if (loop_q) begin
              launch     = 1'b1;
              launch_idx = '0;
            end
          end else begin
            launch     = 1'b1;
            launch_idx = vec_idx + 1'b1;
          end
        end
      end
      default: begin
        launch     = 1'b0;
        launch_idx = '0;
      end
    endcase
  end

  // Table read; indices beyond the table replay as an all-zero, unchecked entry.
  always_comb begin
    launch_ent = '0;
    if (32'(launch_idx) < DEPTH) begin
      launch_ent = table_q[launch_idx];
    end
  end

  assign ent_chk = launch_ent[EntW-1];
  assign ent_rst = launch_ent[EntW-2];
  assign ent_in  = launch_ent[IN_W+OUT_W-1:OUT_W];
  assign ent_exp = launch_ent[OUT_W-1:0];

  assign flush = abort && (state_q != StIdle);
  assign clr   = start && (state_q == StIdle);

  assign mismatch = pipe_vld_q[CHK_LAT-1] && pipe_chk_q[CHK_LAT-1] &&
                    (dut_out != pipe_exp_q[CHK_LAT-1]);

  // Table load: only while idle and only for addresses inside the table.
  always_ff @(posedge clk) begin
    if (ld_en && (state_q == StIdle) && (32'(ld_addr) < DEPTH)) begin
      table_q[ld_addr] <= ld_data;
    end
  end

  // Playback FSM with registered DUT drive and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      dut_rst    <= 1'b1;
      dut_in     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      vec_idx    <= '0;
      last_idx_q <= '0;
      loop_q     <= 1'b0;
      drain_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          dut_rst <= 1'b1;
          dut_in  <= '0;
          if (start) begin
            loop_q     <= loop_en;
            last_idx_q <= ADDR_W'(len - 1'b1);
            if (len == '0) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q <= StRun;
              busy    <= 1'b1;
              vec_idx <= launch_idx;
              dut_rst <= ent_rst;
              dut_in  <= ent_in;
            end
          end
        end
        StRun: begin
          if (abort) begin
            state_q <= StIdle;
            dut_rst <= 1'b1;
            dut_in  <= '0;
            busy    <= 1'b0;
            vec_idx <= '0;
          end else if (launch) begin
            vec_idx <= launch_idx;
            dut_rst <= ent_rst;
            dut_in  <= ent_in;
          end else begin
            // Last vector issued: park the DUT while its final response is checked.
            state_q <= StDrain;
            dut_rst <= 1'b1;
            dut_in  <= '0;
            drain_q <= 3'(CHK_LAT - 1);
          end
        end
        StDrain: begin
          if (abort) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            vec_idx <= '0;
          end else if (drain_q == '0) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          dut_rst <= 1'b1;
          dut_in  <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Compare pipeline: carries {chk, exp, idx} alongside each launched vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CHK_LAT; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_chk_q[i] <= 1'b0;
        pipe_exp_q[i] <= '0;
        pipe_idx_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= launch && !flush;
      pipe_chk_q[0] <= ent_chk;
      pipe_exp_q[0] <= ent_exp;
      pipe_idx_q[0] <= launch_idx;
      for (int unsigned i = 1; i < CHK_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1] && !flush;
        pipe_chk_q[i] <= pipe_chk_q[i-1];
        pipe_exp_q[i] <= pipe_exp_q[i-1];
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end
    end
  end

  // Error accounting: saturating count plus index of the first failure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt   <= '0;
      first_err <= '0;
      err_seen  <= 1'b0;
    end else if (clr) begin
      err_cnt   <= '0;
      first_err <= '0;
      err_seen  <= 1'b0;
    end else if (mismatch && !flush) begin
      if (err_cnt != {ERR_W{1'b1}}) begin
        err_cnt <= err_cnt + 1'b1;
      end
      if (!err_seen) begin
        first_err <= pipe_idx_q[CHK_LAT-1];
        err_seen  <= 1'b1;
      end
    end
  end

endmodule
